// File: rtl/ls153_scan_pkg.sv
// Shared types and constants for the 74LS153 scan sequencer.
package ls153_scan_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } scan_state_e;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);
    localparam int unsigned SETTLE_W  = 4;

endpackage

// File: rtl/scan_slot_ctr.sv
// Slot/settle-timer counter: each slot lasts SETTLE advances, then steps to the next slot.
module scan_slot_ctr
    import ls153_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic [SLOT_W-1:0] slot_next_o,
    output logic              slot_end_o,
    output logic              last_slot_o
);

    localparam logic [SETTLE_W-1:0] LastTick = SETTLE_W'(SETTLE - 1);
    localparam logic [SLOT_W-1:0]   LastSlot = SLOT_W'(NUM_SLOTS - 1);

    logic [SETTLE_W-1:0] timer_q, timer_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;

    always_comb begin
        timer_d = timer_q;
        slot_d  = slot_q;
        if (clear_i) begin
            timer_d = '0;
            slot_d  = '0;
        end else if (advance_i) begin
            if (timer_q == LastTick) begin
                timer_d = '0;
                slot_d  = slot_q + 1'b1;  // wraps to 0 after the last slot
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
            slot_q  <= '0;
        end else begin
            timer_q <= timer_d;
            slot_q  <= slot_d;
        end
    end

    assign slot_o      = slot_q;
    assign slot_next_o = slot_d;
    assign slot_end_o  = (timer_q == LastTick);
    assign last_slot_o = (slot_q == LastSlot);

endmodule

// File: rtl/ls153_scan_seq.sv
// Scan sequencer for a dual 4:1 mux: walks S over all slots, samples Za/Zb once per slot,
// and hands the two assembled words downstream over valid/ready.
module ls153_scan_seq
    import ls153_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1  // 1..15
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 cont,
    output logic                 busy,
    output logic [SLOT_W-1:0]    S,
    output logic                 Ea_b,
    output logic                 Eb_b,
    input  logic                 Za,
    input  logic                 Zb,
    output logic [NUM_SLOTS-1:0] word_a,
    output logic [NUM_SLOTS-1:0] word_b,
    output logic                 valid,
    input  logic                 ready
);

    scan_state_e state_q, state_d;

    logic              ctr_clear, ctr_advance;
    logic [SLOT_W-1:0] slot, slot_next;
    logic              slot_end, last_slot;
    logic              capture;

    logic [SLOT_W-1:0]    s_q, s_d;
    logic                 ea_b_q, eb_b_q, strobe_b_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [NUM_SLOTS-1:0] word_a_q, word_b_q;

    scan_slot_ctr #(
        .SETTLE(SETTLE)
    ) u_slot_ctr (
        .clk_i      (clk),
        .rst_ni     (rst_b),
        .clear_i    (ctr_clear),
        .advance_i  (ctr_advance),
        .slot_o     (slot),
        .slot_next_o(slot_next),
        .slot_end_o (slot_end),
        .last_slot_o(last_slot)
    );

    always_comb begin
        state_d     = state_q;
        ctr_clear   = 1'b0;
        ctr_advance = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StScan;
                    ctr_clear = 1'b1;
                end
            end
            StScan: begin
                ctr_advance = 1'b1;
                if (slot_end) begin
                    capture = 1'b1;
                    if (last_slot) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (ready) begin
                    state_d   = cont ? StScan : StIdle;
                    ctr_clear = cont;
                end
            end
            default: begin
                state_d   = StIdle;
                ctr_clear = 1'b1;
            end
        endcase
    end

    // Outputs are registered: derive their next values from the next state.
    always_comb begin
        s_d        = (state_d == StScan) ? slot_next : '0;
        strobe_b_d = (state_d != StScan);
        busy_d     = (state_d != StIdle);
        valid_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            s_q     <= '0;
            ea_b_q  <= 1'b1;
            eb_b_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ea_b_q  <= strobe_b_d;
            eb_b_q  <= strobe_b_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Bits not yet recaptured in a scan keep their previous value.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            word_a_q <= '0;
            word_b_q <= '0;
        end else if (capture) begin
            word_a_q[slot] <= Za;
            word_b_q[slot] <= Zb;
        end
    end

    assign S      = s_q;
    assign Ea_b   = ea_b_q;
    assign Eb_b   = eb_b_q;
    assign busy   = busy_q;
    assign valid  = valid_q;
    assign word_a = word_a_q;
    assign word_b = word_b_q;

endmodule

// File: tb/tb_ls153_scan_seq.sv
// Bench for ls153_scan_seq: three instances (SETTLE=1,2,3) each scanning a behavioural 74LS153.
module tb_ls153_scan_seq;

    logic       clk;
    logic       rst_b;
    logic       start;
    logic       cont;
    logic       ready;
    logic [3:0] ia;
    logic [3:0] ib;

    logic       busy   [3];
    logic [1:0] s      [3];
    logic       ea_b   [3];
    logic       eb_b   [3];
    logic       za     [3];
    logic       zb     [3];
    logic [3:0] word_a [3];
    logic [3:0] word_b [3];
    logic       valid  [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ls153_scan_seq #(
            .SETTLE(g + 1)
        ) u_dut (
            .clk   (clk),
            .rst_b (rst_b),
            .start (start),
            .cont  (cont),
            .busy  (busy[g]),
            .S     (s[g]),
            .Ea_b  (ea_b[g]),
            .Eb_b  (eb_b[g]),
            .Za    (za[g]),
            .Zb    (zb[g]),
            .word_a(word_a[g]),
            .word_b(word_b[g]),
            .valid (valid[g]),
            .ready (ready)
        );
        // 74LS153 behaviour: strobe high forces the output low.
        assign za[g] = ea_b[g] ? 1'b0 : ia[s[g]];
        assign zb[g] = eb_b[g] ? 1'b0 : ib[s[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ia = 4'hF;
        ib = 4'hF;
        pulse_start();
        repeat (6) tick();
        #3;
        rst_b = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (s[g] !== 2'd0 || ea_b[g] !== 1'b1 || eb_b[g] !== 1'b1 || valid[g] !== 1'b0 ||
                busy[g] !== 1'b0 || word_a[g] !== 4'h0 || word_b[g] !== 4'h0) begin
                errors++;
                $display("FAIL reset_async inst%0d: S=%0d Ea_b=%b Eb_b=%b valid=%b busy=%b wa=%b wb=%b, want all idle/zero",
                         g, s[g], ea_b[g], eb_b[g], valid[g], busy[g], word_a[g], word_b[g]);
            end
        end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        ia = 4'b1010;
        ib = 4'b0110;
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (s[0] !== 2'(c - 1) || ea_b[0] !== 1'b0 || eb_b[0] !== 1'b0 || busy[0] !== 1'b1 ||
                valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL basic_scan cycle %0d: S=%0d Ea_b=%b Eb_b=%b busy=%b valid=%b, want S=%0d strobes 0 busy 1 valid 0",
                         c, s[0], ea_b[0], eb_b[0], busy[0], valid[0], c - 1);
            end
            tick();
        end
        checks++;
        if (valid[0] !== 1'b1 || word_a[0] !== 4'b1010 || word_b[0] !== 4'b0110 ||
            ea_b[0] !== 1'b1 || s[0] !== 2'd0) begin
            errors++;
            $display("FAIL basic_done: valid=%b wa=%b wb=%b Ea_b=%b S=%0d, want 1 1010 0110 1 0",
                     valid[0], word_a[0], word_b[0], ea_b[0], s[0]);
        end
    endtask

    // Continues from test_basic with instance 0 sitting in DONE.
    task automatic test_backpressure();
        ia = 4'b0101;
        ib = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            checks++;
            if (valid[0] !== 1'b1 || word_a[0] !== 4'b1010 || word_b[0] !== 4'b0110 ||
                ea_b[0] !== 1'b1 || eb_b[0] !== 1'b1 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL backpressure hold %0d: valid=%b wa=%b wb=%b Ea_b=%b Eb_b=%b busy=%b, want 1 1010 0110 1 1 1",
                         i, valid[0], word_a[0], word_b[0], ea_b[0], eb_b[0], busy[0]);
            end
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || ea_b[0] !== 1'b1 || s[0] !== 2'd0) begin
                errors++;
                $display("FAIL backpressure idle %0d: valid=%b busy=%b Ea_b=%b S=%0d, want 0 0 1 0",
                         i, valid[0], busy[0], ea_b[0], s[0]);
            end
            tick();
        end
    endtask

    task automatic test_continuous();
        logic [3:0] va [5];
        logic [3:0] vb [5];
        int period;
        period = 4 * 2 + 1;
        va[0] = 4'($urandom);
        vb[0] = 4'($urandom);
        for (int j = 1; j < 5; j++) begin
            va[j] = ~va[j-1];
            vb[j] = 4'($urandom);
        end
        do_reset();
        cont  = 1'b1;
        ready = 1'b1;
        ia = va[0];
        ib = vb[0];
        pulse_start();
        for (int c = 1; c <= 4 * period; c++) begin
            if (c % period == 0) begin
                checks++;
                if (valid[1] !== 1'b1 || word_a[1] !== va[c/period-1] ||
                    word_b[1] !== vb[c/period-1]) begin
                    errors++;
                    $display("FAIL continuous cycle %0d: valid=%b wa=%b wb=%b, want 1 %b %b",
                             c, valid[1], word_a[1], word_b[1], va[c/period-1], vb[c/period-1]);
                end
                ia = va[c/period];
                ib = vb[c/period];
            end else begin
                checks++;
                if (valid[1] !== 1'b0 || busy[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL continuous gap cycle %0d: valid=%b busy=%b, want 0 1",
                             c, valid[1], busy[1]);
                end
            end
            tick();
        end
        cont  = 1'b0;
        ready = 1'b0;
    endtask

    // SETTLE=3 instance; bit `bitn` of Ia rises in cycle `cc` of the scan.
    task automatic run_settle(input int bitn, input int cc, input logic [3:0] init,
                              input string name);
        logic [3:0] base;
        logic [3:0] expa;
        base = init;
        base[bitn] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            expa[n] = (n == bitn) ? (cc <= 3 * (n + 1)) : base[n];
        end
        do_reset();
        ia = base;
        ib = ~base;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (c == cc) ia[bitn] = 1'b1;
            tick();
        end
        checks++;
        if (valid[2] !== 1'b1 || word_a[2] !== expa || word_b[2] !== ~base) begin
            errors++;
            $display("FAIL settle_%s bit%0d cycle%0d: valid=%b wa=%b wb=%b, want 1 %b %b",
                     name, bitn, cc, valid[2], word_a[2], word_b[2], expa, ~base);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_settle();
        run_settle(1, 5, 4'b0000, "second");
        run_settle(1, 6, 4'b0000, "third");
        run_settle(1, 7, 4'b0000, "after");
        for (int i = 0; i < 4; i++) begin
            run_settle(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)),
                       4'($urandom), "rand");
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] a;
        logic [3:0] b;
        a = 4'($urandom);
        b = 4'($urandom);
        do_reset();
        ia = a;
        ib = b;
        pulse_start();
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (valid[2] !== 1'b0) begin
                errors++;
                $display("FAIL abort_novalid cycle %0d: valid=%b, want 0", c, valid[2]);
            end
            tick();
        end
        checks++;
        if (s[2] !== 2'd2) begin
            errors++;
            $display("FAIL abort_slot: S=%0d, want 2", s[2]);
        end
        #3;
        rst_b = 1'b0;
        #1;
        checks++;
        if (valid[2] !== 1'b0 || busy[2] !== 1'b0 || word_a[2] !== 4'h0 || word_b[2] !== 4'h0) begin
            errors++;
            $display("FAIL abort_reset: valid=%b busy=%b wa=%b wb=%b, want 0 0 0000 0000",
                     valid[2], busy[2], word_a[2], word_b[2]);
        end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ia = ~a;
        ib = ~b;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (valid[2] !== 1'b0) begin
                errors++;
                $display("FAIL abort_rescan_early cycle %0d: valid=%b, want 0", c, valid[2]);
            end
            tick();
        end
        checks++;
        if (valid[2] !== 1'b1 || word_a[2] !== ~a || word_b[2] !== ~b) begin
            errors++;
            $display("FAIL abort_rescan: valid=%b wa=%b wb=%b, want 1 %b %b",
                     valid[2], word_a[2], word_b[2], ~a, ~b);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    // Random words with random ready delay; next start is sampled right after each transfer.
    task automatic test_back_to_back();
        logic [3:0] a;
        logic [3:0] b;
        int d;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            ia = a;
            ib = b;
            pulse_start();
            for (int c = 1; c <= 4; c++) begin
                checks++;
                if (valid[0] !== 1'b0 || busy[0] !== 1'b1 || s[0] !== 2'(c - 1)) begin
                    errors++;
                    $display("FAIL b2b_scan it%0d cycle %0d: valid=%b busy=%b S=%0d, want 0 1 %0d",
                             it, c, valid[0], busy[0], s[0], c - 1);
                end
                tick();
            end
            ia = ~a;
            ib = ~b;
            d = int'($urandom_range(0, 3));
            for (int w = 0; w <= d; w++) begin
                checks++;
                if (valid[0] !== 1'b1 || word_a[0] !== a || word_b[0] !== b) begin
                    errors++;
                    $display("FAIL b2b_done it%0d wait %0d: valid=%b wa=%b wb=%b, want 1 %b %b",
                             it, w, valid[0], word_a[0], word_b[0], a, b);
                end
                if (w == d) ready = 1'b1;
                tick();
            end
            ready = 1'b0;
            checks++;
            if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle it%0d: valid=%b busy=%b, want 0 0", it, valid[0], busy[0]);
            end
        end
    endtask

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        ready = 1'b0;
        ia    = 4'h0;
        ib    = 4'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_continuous();
        test_settle();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ls153_scan_seq.md
# ls153_scan_seq

Scan sequencer for a dual 4-to-1 TTL multiplexer stage (74LS153 model). It drives the mux select and active-low strobe lines, walks S through all four input slots, and samples the Za/Zb outputs once per slot. The samples are assembled into two 4-bit words, which are handed downstream over a valid/ready handshake. It sits between a system-level scan trigger and the mux instance: it is the mux's select/strobe driver upstream and the consumer of its outputs downstream.

## Interface
Parameters:
- SETTLE, default 1: cycles each select value is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- cont  input  1  continuous mode; when high at handshake, the next scan begins immediately.
- busy  output  1  high in SCAN and DONE.
- S  output  2  mux select, registered.
- Ea_b  output  1  channel A strobe, active low, registered.
- Eb_b  output  1  channel B strobe, active low, registered.
- Za  input  1  mux channel A output.
- Zb  input  1  mux channel B output.
- word_a  output  4  captured channel A word; bit n = Za sampled with S=n.
- word_b  output  4  captured channel B word; bit n = Zb sampled with S=n.
- valid  output  1  words available.
- ready  input  1  downstream accepts the words.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE
  - S=0, Ea_b=Eb_b=1, busy=0, valid=0.
  - start=1 → SCAN with slot=0, timer=0.
- SCAN
  - Ea_b=Eb_b=0; S=slot.
  - The timer counts 0..SETTLE-1.
  - At the edge where timer==SETTLE-1, capture Za into word_a[slot] and Zb into word_b[slot].
  - On that edge, if slot<3: slot+1, timer=0. If slot==3: go to DONE.
- DONE
  - Ea_b=Eb_b=1, S=0, valid=1; words held stable.
  - valid&&ready at an edge completes the transfer.
  - After the transfer: cont=1 → SCAN (slot=0, timer=0); cont=0 → IDLE.
- start is ignored in SCAN and DONE. It is not queued.
- Word bits not yet recaptured during a scan keep their previous values. After a completed scan, all 4 bits are fresh.
- word_a/word_b change only at capture edges. They remain stable from DONE until the next scan overwrites them.
- Reset (asynchronous, any state): state=IDLE, S=0, Ea_b=Eb_b=1, busy=0, valid=0, word_a=word_b=0, slot=timer=0.
- A scan interrupted by reset is discarded. No partial word is presented.

## Timing
- Edge 0 samples start=1. In cycle 1, S=0, the strobes are low, and busy=1.
- Each slot occupies SETTLE cycles. The sample is taken at the final edge of the slot, so Z has SETTLE cycles to settle through the combinational mux.
- The final sample is at edge 4·SETTLE. valid=1 from cycle 4·SETTLE+1.
- Minimum start-to-valid latency is 4·SETTLE+1 cycles.
- Transfer edge T with cont=1: valid=0 and S=0 (slot 0) in cycle T+1.
  - Back-to-back period is 4·SETTLE+1 cycles with ready held high.
- Transfer edge T with cont=0: IDLE in cycle T+1. The earliest next start is sampled at edge T+1.
- Za/Zb are treated as synchronous to clk. No synchronizer.

## Structure
- Shared package ls153_scan_pkg:
  - state enum typedef (IDLE, SCAN, DONE);
  - constant NUM_SLOTS=4;
  - constant SETTLE_W=4 (timer width).
- One sub-module, scan_slot_ctr: slot/timer counter with clear, advance, and last_slot/slot_end flags.
- FSM, capture registers and handshake live in the top level.
- The bench instantiates ls153 as the device under scan.

## Test plan
- Reset: assert rst_b=0 mid-cycle → S=0, Ea_b=Eb_b=1, valid=busy=0, words=0 immediately, without waiting for a clock.
- SETTLE=1, Ia=4'b1010, Ib=4'b0110, start pulse at edge 0 → S goes 0,1,2,3 in cycles 1–4; valid=1 in cycle 5 with word_a=4'b1010 and word_b=4'b0110.
- Backpressure: ready=0 for 10 cycles after valid → valid, word_a and word_b stable; start pulses ignored; the strobes stay high. ready=1 → IDLE next cycle.
- Continuous: SETTLE=2, cont=1, ready=1, Ia toggled between scans → valid pulses every 9 cycles; each word reflects the Ia value during its scan.
- Settle: SETTLE=3, Ia[1] changed from 0 to 1 in the second cycle of slot 1 → word_a[1]=1. With the change in the third cycle → still captured as 1. With the change one cycle after the slot ends → 0.
- Reset during slot 2, then release and start → the fresh scan returns the full correct word; no stale bits; valid is never asserted for the aborted scan.
